// File: rtl/alm_pkg.sv
// Shared definitions for the pipelined set-one-adder logarithmic multiplier:
// width derivations, parameter legality and the bit-exact reference model.
package alm_pkg;

  function automatic int alm_kw(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic int alm_k(input int width, input int w);
    return width - 1 - w;
  endfunction

  function automatic bit alm_params_ok(input int width, input int w);
    return (width == 8 || width == 16 || width == 32) && (w >= 1) && (w <= width - 3);
  endfunction

  // Arithmetic description of the approximation, written without the
  // hardware's shifter structure; the product is zero-extended to 64 bits.
  function automatic logic [63:0] alm_soa_ref(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn, input int width, input int w);
    logic [63:0] mask, oa, ob, fa, fb, sla, slb, sum, mant, prod;
    logic        sa, sb;
    int          ka, kb, kf, ks;
    kf   = width - 1 - w;
    mask = (64'd1 << width) - 64'd1;
    oa   = {32'd0, a} & mask;
    ob   = {32'd0, b} & mask;
    sa   = sgn & oa[width-1];
    sb   = sgn & ob[width-1];
    fa   = sa ? (~oa & mask) : oa;
    fb   = sb ? (~ob & mask) : ob;
    ka   = 0;
    kb   = 0;
    for (int i = 0; i < width; i++) begin
      if (fa[i]) ka = i;
      if (fb[i]) kb = i;
    end
    fa   = fa & ~(64'd1 << ka);
    fb   = fb & ~(64'd1 << kb);
    sla  = (fa << (width - 1 - ka)) >> (w - 1);
    slb  = (fb << (width - 1 - kb)) >> (w - 1);
    sum  = (sla >> 1) + (slb >> 1) + (sla & slb & 64'd1);
    ks   = ka + kb + int'(sum >> kf);
    mant = (64'd1 << (width - 1)) | ((sum & ((64'd1 << kf) - 64'd1)) << w)
         | ((64'd1 << w) - 64'd1);
    prod = (ks >= width - 1) ? (mant << (ks - (width - 1))) : (mant >> (width - 1 - ks));
    if (oa == 64'd0 || ob == 64'd0) return 64'd0;
    if (sa ^ sb) prod = ~prod & ((64'd1 << (2 * width)) - 64'd1);
    return prod;
  endfunction

endpackage

// File: rtl/alm_log_encode.sv
// Combinational log encoder: one's-complement magnitude, leading-one index
// and the left-aligned K+1-bit fraction slice below the leading one.
module alm_log_encode
  import alm_pkg::*;
#(
  parameter int  WIDTH = 16,
  parameter int  W     = 11,
  localparam int KW    = alm_kw(WIDTH),
  localparam int K     = alm_k(WIDTH, W)
) (
  input  logic [WIDTH-1:0] operand,
  input  logic             in_signed,
  output logic [KW-1:0]    k,
  output logic [K:0]       frac,
  output logic             s,
  output logic             z
);

  logic [WIDTH-1:0] m;
  logic [KW-1:0]    shamt;

  always_comb begin
    s = in_signed & operand[WIDTH-1];
    m = operand ^ {WIDTH{s}};
    z = (operand == '0);
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (m[i]) k = KW'(i);
    end
    // Leading one lands at the MSB and is truncated away; m = 0 yields zero.
    shamt = KW'(WIDTH - 1) - k;
    frac  = (K + 1)'((m << shamt) >> (W - 1));
  end

endmodule

// File: rtl/alm_soa_pipe.sv
// Three-stage ALM-SOA approximate multiplier with valid/ready streaming and
// a single global enable so stalls freeze every stage, bubbles included.
module alm_soa_pipe
  import alm_pkg::*;
#(
  parameter int  WIDTH = 16,
  parameter int  W     = 11,
  localparam int KW    = alm_kw(WIDTH),
  localparam int K     = alm_k(WIDTH, W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  if (!alm_params_ok(WIDTH, W)) begin : g_param_check
    $error("alm_soa_pipe: illegal parameters WIDTH=%0d W=%0d", WIDTH, W);
  end

  logic en;
  logic vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q, vld_p3_d, vld_p3_q;

  logic [KW-1:0] kx_p1_d, ky_p1_d, kx_p1_q, ky_p1_q;
  logic [K:0]    fx_p1_d, fy_p1_d, fx_p1_q, fy_p1_q;
  logic          sx_p1_d, sy_p1_d, sx_p1_q, sy_p1_q;
  logic          zx_p1_d, zy_p1_d, zx_p1_q, zy_p1_q;

  logic [K:0]    fadd;
  logic [KW-1:0] ksum_p2_d, ksum_p2_q;
  logic [K-1:0]  fhi_p2_d, fhi_p2_q;
  logic          sgn_p2_d, sgn_p2_q, zero_p2_d, zero_p2_q;

  logic [WIDTH-1:0]   mant;
  logic [2*WIDTH-1:0] mag;
  logic [2*WIDTH-1:0] p_p3_d, p_p3_q;

  assign en        = ~vld_p3_q | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p3_q;
  assign p         = vld_p3_q ? p_p3_q : '0;

  always_comb begin
    vld_p1_d = en ? in_valid : vld_p1_q;
    vld_p2_d = en ? vld_p1_q : vld_p2_q;
    vld_p3_d = en ? vld_p2_q : vld_p3_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
    end
  end

  // S1: log encode both operands
  alm_log_encode #(.WIDTH(WIDTH), .W(W)) u_enc_x (
    .operand(x), .in_signed(in_signed), .k(kx_p1_d), .frac(fx_p1_d), .s(sx_p1_d), .z(zx_p1_d)
  );

  alm_log_encode #(.WIDTH(WIDTH), .W(W)) u_enc_y (
    .operand(y), .in_signed(in_signed), .k(ky_p1_d), .frac(fy_p1_d), .s(sy_p1_d), .z(zy_p1_d)
  );

  // S2: set-one adder; the dropped LSB pair becomes the carry-in
  always_comb begin
    fadd      = {1'b0, fx_p1_q[K:1]} + {1'b0, fy_p1_q[K:1]}
              + (K + 1)'(fx_p1_q[0] & fy_p1_q[0]);
    fhi_p2_d  = fadd[K-1:0];
    ksum_p2_d = kx_p1_q + ky_p1_q + KW'(fadd[K]);
    sgn_p2_d  = sx_p1_q ^ sy_p1_q;
    zero_p2_d = zx_p1_q | zy_p1_q;
  end

  // S3: antilog shift and one's-complement sign application
  always_comb begin
    mant = {1'b1, fhi_p2_q, {W{1'b1}}};
    if (ksum_p2_q >= KW'(WIDTH - 1)) begin
      mag = {{WIDTH{1'b0}}, mant} << (ksum_p2_q - KW'(WIDTH - 1));
    end else begin
      mag = {{WIDTH{1'b0}}, mant} >> (KW'(WIDTH - 1) - ksum_p2_q);
    end
    p_p3_d = zero_p2_q ? '0 : (mag ^ {2*WIDTH{sgn_p2_q}});
  end

  always_ff @(posedge clk) begin
    if (en) begin
      kx_p1_q   <= kx_p1_d;
      ky_p1_q   <= ky_p1_d;
      fx_p1_q   <= fx_p1_d;
      fy_p1_q   <= fy_p1_d;
      sx_p1_q   <= sx_p1_d;
      sy_p1_q   <= sy_p1_d;
      zx_p1_q   <= zx_p1_d;
      zy_p1_q   <= zy_p1_d;
      ksum_p2_q <= ksum_p2_d;
      fhi_p2_q  <= fhi_p2_d;
      sgn_p2_q  <= sgn_p2_d;
      zero_p2_q <= zero_p2_d;
      p_p3_q    <= p_p3_d;
    end
  end

endmodule

// File: tb/tb_alm_soa_pipe.sv
// Directed and swept checks of alm_soa_pipe: latency, signed/unsigned
// products, backpressure ordering, mid-flight reset and parameter variants.
module tb_alm_soa_pipe;
  import alm_pkg::*;

  localparam int SWEEP_N = 1200;

  logic        clk = 1'b0;
  logic        rst, rst_s;
  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [15:0] x, y;
  logic [31:0] p;
  logic [7:0]  sweep_done;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  alm_soa_pipe #(.WIDTH(16), .W(11)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int cfg_width(input int g);
    case (g)
      0, 1, 2: return 8;
      3, 4, 5: return 32;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_w(input int g);
    case (g)
      0:       return 1;
      1:       return 4;
      2:       return 5;
      3:       return 1;
      4:       return 16;
      5:       return 29;
      6:       return 1;
      default: return 13;
    endcase
  endfunction

  task automatic send_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sgn, input logic [31:0] exp);
    @(negedge clk);
    x = a; y = b; in_signed = sgn; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; x = '0; y = '0;
    check($sformatf("%s_lat1", tag), 64'(out_valid), 64'd0);
    @(negedge clk);
    check($sformatf("%s_lat2", tag), 64'(out_valid), 64'd0);
    @(negedge clk);
    check($sformatf("%s_lat3", tag), 64'(out_valid), 64'd1);
    check(tag, 64'(p), 64'(exp));
    check($sformatf("%s_ref", tag), 64'(p), alm_soa_ref(32'(a), 32'(b), sgn, 16, 11));
  endtask

  initial begin
    logic [15:0] bx[8];
    logic [15:0] by[8];
    logic        bs[8];
    logic [31:0] exp_q[$];
    logic [31:0] held_p;
    logic        held_v;
    int          sent, got, cyc;

    rst = 1'b1; rst_s = 1'b1; in_valid = 1'b0; in_signed = 1'b0;
    x = '0; y = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_p", 64'(p), 64'd0);
    rst = 1'b0; rst_s = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    send_one("u_3x5",       16'd3,      16'd5,    1'b0, 32'h0000000E);
    send_one("u_256x1024",  16'd256,    16'd1024, 1'b0, 32'h00043FF8);
    send_one("u_fffdx5",    16'hFFFD,   16'd5,    1'b0, 32'h0004FFF8);
    send_one("s_m3x5",      16'hFFFD,   16'd5,    1'b1, 32'hFFFFFFF5);
    send_one("s_0x1234",    16'd0,      16'd1234, 1'b1, 32'h00000000);
    send_one("s_m1x5",      16'hFFFF,   16'd5,    1'b1, 32'hFFFFFFFA);

    // Backpressure: eight pairs, consumer stalls for cycles 4..9
    for (int i = 0; i < 8; i++) begin
      bx[i] = 16'($urandom);
      by[i] = 16'($urandom);
      bs[i] = i[0];
    end
    sent = 0; got = 0; cyc = 0; held_v = 1'b0; held_p = '0;
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      if (held_v) check("stall_p_hold", 64'(p), 64'(held_p));
      out_ready = !(cyc >= 4 && cyc <= 9);
      if (sent < 8) begin
        in_valid = 1'b1; x = bx[sent]; y = by[sent]; in_signed = bs[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      held_v = out_valid && !out_ready;
      held_p = p;
      if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("bp_extra_output", 64'd1, 64'd0);
        else check($sformatf("bp_p%0d", got), 64'(p), 64'(exp_q.pop_front()));
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(32'(alm_soa_ref(32'(x), 32'(y), in_signed, 16, 11)));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_count", 64'(got), 64'd8);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset with three transactions in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x = 16'(i + 7); y = 16'd9; in_signed = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_mid_pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_p", 64'(p), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_after_valid", 64'(out_valid), 64'd0);
    send_one("post_rst_3x5", 16'd3, 16'd5, 1'b0, 32'h0000000E);

    for (int i = 0; i < 20000 && sweep_done != 8'hFF; i++) @(negedge clk);
    check("sweep_done", 64'(sweep_done), 64'hFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  for (genvar g = 0; g < 8; g++) begin : g_sweep
    localparam int WT = cfg_width(g);
    localparam int WS = cfg_w(g);

    logic [WT-1:0]   gx, gy;
    logic            gs, gv, grdy, gov, done;
    logic [2*WT-1:0] gp;
    logic [63:0]     q[$];

    assign sweep_done[g] = done;

    alm_soa_pipe #(.WIDTH(WT), .W(WS)) u_sweep (
      .clk(clk), .rst(rst_s), .in_valid(gv), .in_ready(grdy), .in_signed(gs),
      .x(gx), .y(gy), .out_valid(gov), .out_ready(1'b1), .p(gp)
    );

    function automatic logic [WT-1:0] pick();
      logic [WT-1:0] v;
      case ($urandom_range(0, 7))
        0:       v = '0;
        1:       v = '1;
        2:       v = {1'b1, {(WT-1){1'b0}}};
        default: v = WT'($urandom);
      endcase
      return v;
    endfunction

    initial begin
      done = 1'b0; gv = 1'b0; gs = 1'b0; gx = '0; gy = '0;
      @(negedge clk);
      for (int i = 0; i < 100 && rst_s; i++) @(negedge clk);
      for (int c = 0; c < SWEEP_N + 10; c++) begin
        @(negedge clk);
        if (gov) begin
          if (q.size() == 0) check($sformatf("sweep_w%0d_%0d_extra", WT, WS), 64'd1, 64'd0);
          else check($sformatf("sweep_w%0d_%0d", WT, WS), 64'(gp), q.pop_front());
        end
        if (c < SWEEP_N && grdy) begin
          gx = pick(); gy = pick(); gs = 1'($urandom_range(0, 1)); gv = 1'b1;
          q.push_back(alm_soa_ref(32'(gx), 32'(gy), gs, WT, WS));
        end else begin
          gv = 1'b0;
        end
      end
      check($sformatf("sweep_w%0d_%0d_drain", WT, WS), 64'(q.size()), 64'd0);
      done = 1'b1;
    end
  end

endmodule
